mux_sel_sequencer: RTL and testbench



---
 rtl/logic_pkg.sv | 19 +
 rtl/v74161.sv | 43 ++++
 rtl/mux_sel_sequencer.sv | 146 ++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared types and constants for the mux select sequencer.
// The dwell timer counts up from DWELL_MAX - dwell and reloads when it reaches DWELL_MAX.
package logic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    PAUSE
  } seq_state_t;

  localparam logic [3:0] DWELL_MAX = 4'd15;

  // Preload value that makes the counter reach terminal count after dwell+1 counted cycles.
  function automatic logic [3:0] dwell_preload(input logic [3:0] dwell);
    return DWELL_MAX - dwell;
  endfunction

endpackage

// File: rtl/v74161.sv
// Catalogue model of a 74161 synchronous 4-bit binary counter.
// Asynchronous clear, synchronous load, and count enabled by ENP & ENT.
module v74161 (
  input  logic clr_n,   // pin 1
  input  logic clk,     // pin 2
  input  logic a,       // pin 3
  input  logic b,       // pin 4
  input  logic c,       // pin 5
  input  logic d,       // pin 6
  input  logic enp,     // pin 7
  input  logic load_n,  // pin 9
  input  logic ent,     // pin 10
  output logic qd,      // pin 11
  output logic qc,      // pin 12
  output logic qb,      // pin 13
  output logic qa,      // pin 14
  output logic rco      // pin 15
);

  logic [3:0] cnt_q, cnt_d;

  // Load overrides the count enables, as on the real part.
  always_comb begin
    cnt_d = cnt_q;
    if (!load_n) begin
      cnt_d = {d, c, b, a};
    end else if (enp && ent) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign {qd, qc, qb, qa} = cnt_q;
  assign rco              = ent & (cnt_q == 4'hF);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Steps a registered mux select through a loaded bit pattern, holding each bit for
// dwell+1 cycles as timed by a 74161 counter.
module mux_sel_sequencer
  import logic_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned IDX_W = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       dwell,
  input  logic             run,
  output logic             s,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             busy,
  output logic             armed
);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(PAT_W - 1);

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       dwell_q, dwell_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic             s_q, s_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             armed_q, armed_d;

  logic       tmr_en;
  logic       tmr_load_n;
  logic       tmr_rco;
  logic [3:0] tmr_pre;
  logic [3:0] tmr_cnt;
  logic       unused_tmr_cnt;

  assign tmr_pre        = dwell_preload(dwell_q);
  assign unused_tmr_cnt = ^tmr_cnt;

  v74161 u_dwell_tmr (
    .clr_n  (reset_n),
    .clk    (clk),
    .a      (tmr_pre[0]),
    .b      (tmr_pre[1]),
    .c      (tmr_pre[2]),
    .d      (tmr_pre[3]),
    .enp    (tmr_en),
    .load_n (tmr_load_n),
    .ent    (tmr_en),
    .qd     (tmr_cnt[3]),
    .qc     (tmr_cnt[2]),
    .qb     (tmr_cnt[1]),
    .qa     (tmr_cnt[0]),
    .rco    (tmr_rco)
  );

  // Timer is held at its preload outside RUN, frozen in PAUSE, and self-reloads on RCO.
  always_comb begin
    tmr_en     = 1'b0;
    tmr_load_n = 1'b1;
    unique case (state_q)
      IDLE, ARMED: tmr_load_n = 1'b0;
      RUN: begin
        tmr_en     = 1'b1;
        tmr_load_n = ~tmr_rco;
      end
      PAUSE: tmr_load_n = 1'b1;
      default: tmr_load_n = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load) state_d = ARMED;
      end
      ARMED: begin
        if (!load && run) state_d = RUN;
      end
      RUN: begin
        if (load)      state_d = ARMED;
        else if (!run) state_d = PAUSE;
      end
      PAUSE: begin
        if (load)     state_d = ARMED;
        else if (run) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat_d   = pat_q;
    dwell_d = dwell_q;
    idx_d   = idx_q;
    s_d     = s_q;
    wrap_d  = 1'b0;
    idx_nxt = (idx_q == IdxLast) ? '0 : idx_q + IDX_W'(1);
    if (load) begin
      pat_d   = pattern;
      dwell_d = dwell;
      idx_d   = '0;
      s_d     = pattern[0];
    end else if (state_q == RUN && tmr_rco) begin
      idx_d  = idx_nxt;
      s_d    = pat_q[idx_nxt];
      // Suppress the pulse if this edge drops into PAUSE.
      wrap_d = (idx_q == IdxLast) && run;
    end
    busy_d  = (state_d == RUN);
    armed_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      dwell_q <= 4'd0;
      idx_q   <= '0;
      s_q     <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign s     = s_q;
  assign idx   = idx_q;
  assign wrap  = wrap_q;
  assign busy  = busy_q;
  assign armed = armed_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: reset, fast pattern, dwell, pause, load priority,
// and reset during RUN.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] pattern;
  logic [3:0] dwell;
  logic       run;
  logic       s;
  logic [2:0] idx;
  logic       wrap;
  logic       busy;
  logic       armed;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(
    .PAT_W (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .pattern (pattern),
    .dwell   (dwell),
    .run     (run),
    .s       (s),
    .idx     (idx),
    .wrap    (wrap),
    .busy    (busy),
    .armed   (armed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Checks {s, idx, wrap, busy, armed} in one go.
  task automatic chk_all(input string tag, input int cyc, input logic es, input logic [2:0] ei,
                         input logic ew, input logic eb, input logic ea);
    chk(tag, cyc, {1'b0, s, idx, wrap, busy, armed}, {1'b0, es, ei, ew, eb, ea});
  endtask

  initial begin
    logic [9:0] fast_s;
    reset_n = 1'b0;
    load    = 1'b0;
    pattern = 8'h00;
    dwell   = 4'd0;
    run     = 1'b0;

    // 1. Reset and idle.
    #12;
    chk_all("reset_state", 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    run     = 1'b1;
    repeat (3) tick();
    chk_all("idle_ignores_run", 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // 2. Fast pattern, dwell 0.
    run     = 1'b0;
    load    = 1'b1;
    pattern = 8'b1010_0110;
    dwell   = 4'd0;
    tick();
    chk_all("fast_armed", 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    run  = 1'b1;
    tick();
    fast_s = 10'b10_1010_0110;
    for (int i = 1; i <= 10; i++) begin
      chk_all("fast_run", i, fast_s[i-1], 3'((i - 1) % 8), (i == 9), 1'b1, 1'b1);
      tick();
    end

    // 3. Dwell 3, single set bit: 4 cycles high, 28 low, period 32.
    run     = 1'b0;
    load    = 1'b1;
    pattern = 8'h01;
    dwell   = 4'd3;
    tick();
    chk_all("dwell_armed", 0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    run  = 1'b1;
    tick();
    for (int i = 1; i <= 36; i++) begin
      chk_all("dwell_run", i, (((i - 1) % 32) < 4), 3'(((i - 1) % 32) / 4), (i == 33), 1'b1,
              1'b1);
      tick();
    end

    // 4. Pause after 2 cycles of bit 0 with dwell 5; 4 cycles of bit 0 remain.
    run     = 1'b0;
    load    = 1'b1;
    pattern = 8'h01;
    dwell   = 4'd5;
    tick();
    load = 1'b0;
    run  = 1'b1;
    tick();
    chk_all("pause_run1", 1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("pause_run2", 2, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    run = 1'b0;
    tick();
    for (int i = 1; i <= 7; i++) begin
      chk_all("paused", i, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
      if (i < 7) tick();
    end
    run = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk_all("resumed_bit0", i, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    chk_all("resumed_bit1", 5, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1);

    // 5. Load has priority over run.
    run     = 1'b0;
    load    = 1'b1;
    pattern = 8'h3F;
    dwell   = 4'd0;
    tick();
    load = 1'b0;
    run  = 1'b1;
    tick();
    repeat (5) tick();
    chk_all("prio_at_idx5", 0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1);
    load    = 1'b1;
    pattern = 8'hF0;
    tick();
    chk_all("prio_armed", 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    tick();
    chk_all("prio_run_bit0", 1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    chk_all("prio_run_bit4", 5, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1);

    // 6. Reset mid-run at idx 3 with dwell 7.
    run     = 1'b0;
    load    = 1'b1;
    pattern = 8'h08;
    dwell   = 4'd7;
    tick();
    load = 1'b0;
    run  = 1'b1;
    tick();
    repeat (24) tick();
    chk_all("rst_before", 25, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk_all("rst_idle_run", 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    load    = 1'b1;
    pattern = 8'h01;
    dwell   = 4'd0;
    tick();
    chk_all("rst_reload_armed", 0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    tick();
    chk_all("rst_reload_run", 1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
